// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the parametrised register file.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sweep controller: zeroes one array entry per cycle after reset or a clr request.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RF_IDLE  | array usable, normal writes accepted
// RF_CLEAR | sweeping: entry ptr is zeroed each cycle, reads forced to 0
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output rf_state_e         state,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    rf_state_e         state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RF_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // The sweep ends on the last-entry compare; the pointer is left to wrap to 0.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            RF_IDLE: begin
                if (clr) begin
                    state_nxt = RF_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            RF_CLEAR: begin
                ptr_nxt = ptr + 1'b1;
                if (clr) begin
                    ptr_nxt = '0;
                end else if (ptr == PTR_LAST) begin
                    state_nxt = RF_IDLE;
                end
            end
            default: begin
                state_nxt = RF_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = (state == RF_CLEAR);
    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2R1W register file with sweep clear; optional write-to-read
// forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              D_En,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D,
    input  logic [ADDR_W-1:0] S_Addr,
    input  logic [ADDR_W-1:0] T_Addr,
    output logic [DATA_W-1:0] S,
    output logic [DATA_W-1:0] T,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    rf_state_e         state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              zero_hit;
    logic              wr_ok;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .state    (state),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign zero_hit = (ZERO_REG != 0) && (D_Addr == '0);
    assign wr_ok    = D_En && (state == RF_IDLE) && !clr && !zero_hit;

    // No reset on the storage itself so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[D_Addr] <= D;
        end
    end

    // Writes to the hardwired zero register are ignored without a drop report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= D_En && ((state == RF_CLEAR) || clr) && !zero_hit;
        end
    end

    always_comb begin
        S = mem[S_Addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (D_Addr == S_Addr)) begin
            S = D;
        end
`endif
        if ((state == RF_CLEAR) || ((ZERO_REG != 0) && (S_Addr == '0))) begin
            S = '0;
        end
    end

    always_comb begin
        T = mem[T_Addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (D_Addr == T_Addr)) begin
            T = D;
        end
`endif
        if ((state == RF_CLEAR) || ((ZERO_REG != 0) && (T_Addr == '0))) begin
            T = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: ZERO_REG=1 and ZERO_REG=0 instances share stimulus and
// are compared each cycle against a behavioural model, plus literal spot checks.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clr = 1'b0;
    logic        D_En = 1'b0;
    logic [4:0]  D_Addr = '0;
    logic [31:0] D = '0;
    logic [4:0]  S_Addr = '0;
    logic [4:0]  T_Addr = '0;

    logic [31:0] S_z, T_z, S_n, T_n;
    logic        busy_z, drop_z, busy_n, drop_n;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .clr(clr), .D_En(D_En), .D_Addr(D_Addr), .D(D),
        .S_Addr(S_Addr), .T_Addr(T_Addr), .S(S_z), .T(T_z), .busy(busy_z), .wr_drop(drop_z)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
        .clk(clk), .reset(reset), .clr(clr), .D_En(D_En), .D_Addr(D_Addr), .D(D),
        .S_Addr(S_Addr), .T_Addr(T_Addr), .S(S_n), .T(T_n), .busy(busy_n), .wr_drop(drop_n)
    );

    // Model: k=0 is the zero-register instance, k=1 the plain one.
    logic [31:0] m_mem [2][32];
    bit          m_clearing = 1'b1;
    int          m_swept = 0;
    bit          m_drop [2] = '{1'b0, 1'b0};

    function automatic bit zr_hit(input int k, input logic [4:0] a);
        return (k == 0) && (a == 5'd0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clearing = 1'b1;
            m_swept    = 0;
            m_drop     = '{1'b0, 1'b0};
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_drop[k] = D_En && (m_clearing || clr) && !zr_hit(k, D_Addr);
                if (m_clearing)
                    m_mem[k][m_swept] = '0;
                else if (D_En && !clr && !zr_hit(k, D_Addr))
                    m_mem[k][D_Addr] = D;
            end
            if (m_clearing) begin
                if (clr) m_swept = 0;
                else if (m_swept == 31) m_clearing = 1'b0;
                else m_swept = m_swept + 1;
            end else if (clr) begin
                m_clearing = 1'b1;
                m_swept    = 0;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
        if (m_clearing || zr_hit(k, a)) return '0;
        if (BYP && D_En && !clr && (D_Addr == a) && !zr_hit(k, D_Addr)) return D;
        return m_mem[k][a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy_z", {31'd0, busy_z}, {31'd0, m_clearing});
            check("busy_n", {31'd0, busy_n}, {31'd0, m_clearing});
            check("drop_z", {31'd0, drop_z}, {31'd0, m_drop[0]});
            check("drop_n", {31'd0, drop_n}, {31'd0, m_drop[1]});
            check("S_z", S_z, exp_rd(0, S_Addr));
            check("T_z", T_z, exp_rd(0, T_Addr));
            check("S_n", S_n, exp_rd(1, S_Addr));
            check("T_n", T_n, exp_rd(1, T_Addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        D_En = 1'b1; D_Addr = a; D = d;
        step();
        D_En = 1'b0;
    endtask

    // Counts busy cycles from now until the first IDLE negedge, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy_z && n < 40) begin
            n++;
            @(negedge clk);
        end
        step();
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset sweep length and all-zero contents afterwards.
        wait_idle(n);
        check("reset_sweep_len", n, 32);
        for (int i = 0; i < 32; i++) begin
            S_Addr = 5'(i); T_Addr = 5'(31 - i);
            @(negedge clk);
            check("post_reset_S", S_n, 32'd0);
            step();
        end

        // Basic write/read.
        S_Addr = 5'd5; T_Addr = 5'd31;
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd31, 32'h12345678);
        @(negedge clk);
        check("basic_S", S_z, 32'hDEADBEEF);
        check("basic_T", T_z, 32'h12345678);
        check("basic_drop", {31'd0, drop_z}, 32'd0);
        step();

        // Zero register.
        S_Addr = 5'd0;
        wr(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        check("zero_reg_S", S_z, 32'd0);
        check("zero_reg_drop", {31'd0, drop_z}, 32'd0);
        check("plain_reg0_S", S_n, 32'hFFFFFFFF);
        step();

        // Clear mid-operation with a write during the sweep.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000 + 32'(i));
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        wr(5'd7, 32'hCAFEF00D);
        @(negedge clk);
        check("sweep_write_drop", {31'd0, drop_z}, 32'd1);
        step();
        wait_idle(n);
        check("clr_sweep_done", {31'd0, (n < 40)}, 32'd1);
        S_Addr = 5'd7; T_Addr = 5'd20;
        @(negedge clk);
        check("clr_addr7", S_n, 32'd0);
        check("clr_addr20", T_n, 32'd0);
        step();

        // Reset part-way through a sweep restarts it at full length.
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_idle(n);
        check("reset_mid_sweep_len", n, 32);

        // clr and a write in the same IDLE cycle.
        wr(5'd3, 32'h11111111);
        clr = 1'b1; D_En = 1'b1; D_Addr = 5'd3; D = 32'hA5A5A5A5;
        step();
        clr = 1'b0; D_En = 1'b0;
        @(negedge clk);
        check("collision_drop", {31'd0, drop_z}, 32'd1);
        step();
        wait_idle(n);
        S_Addr = 5'd3;
        @(negedge clk);
        check("collision_addr3", S_n, 32'd0);
        step();

        // Same-cycle forwarding.
        S_Addr = 5'd9; T_Addr = 5'd9;
        D_En = 1'b1; D_Addr = 5'd9; D = 32'h42;
        @(negedge clk);
        check("bypass_same_cycle", S_z, BYP ? 32'h42 : 32'h0);
        step();
        D_En = 1'b0;
        @(negedge clk);
        check("bypass_next_cycle", S_z, 32'h42);
        check("same_addr_ports", T_z, 32'h42);
        step();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            D_En   = 1'($urandom_range(0, 1));
            D_Addr = 5'($urandom_range(0, 31));
            D      = $urandom;
            S_Addr = ($urandom_range(0, 3) == 0) ? D_Addr : 5'($urandom_range(0, 31));
            T_Addr = ($urandom_range(0, 3) == 0) ? D_Addr : 5'($urandom_range(0, 31));
            clr    = ($urandom_range(0, 79) == 0);
            reset  = ($urandom_range(0, 599) == 0);
            step();
            reset = 1'b0;
        end
        clr = 1'b0; D_En = 1'b0;
        step();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
